core_switch_ctrl: RTL

Dual-core redundancy controller that decides which of two cores (A, B) owns the shared outputs. It consumes the per-core health flags produced by the heartbeat pulse detectors (1 kHz / 50 % PWM checkers) plus two manual force inputs. It drives the output-mux select and per-core enables using break-before-make switching. A minimum-dwell timer prevents ping-pong between cores.

---
 rtl/core_switch_ctrl_pkg.sv | 14 +
 rtl/sync2.sv | 12 +
 rtl/core_switch_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/core_switch_ctrl_pkg.sv
// core_switch_ctrl_pkg: state encodings and default timing for the A/B core switch controller
package core_switch_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RUN_A = 3'd1,
    ST_RUN_B = 3'd2,
    ST_SW_A  = 3'd3,
    ST_SW_B  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;
  localparam int DEF_HOLDOFF     = 16;
  localparam int DEF_MIN_DWELL   = 14746;
  localparam int DEF_REVERT_TIME = 147456;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer, async active-high reset to 0
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/core_switch_ctrl.sv
// core_switch_ctrl: break-before-make A/B core ownership with dwell and holdoff timing.
// Define CORE_SWITCH_REVERT_EN for automatic revert from B back to a persistently healthy A.
module core_switch_ctrl
  import core_switch_ctrl_pkg::*;
#(
  parameter int HOLDOFF   = DEF_HOLDOFF,
  parameter int MIN_DWELL = DEF_MIN_DWELL
`ifdef CORE_SWITCH_REVERT_EN
  , parameter int REVERT_TIME = DEF_REVERT_TIME
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_ok,
  input  logic       b_ok,
  input  logic       force_a,
  input  logic       force_b,
  output logic       sel_a,
  output logic       a_en,
  output logic       b_en,
  output logic       fault,
  output logic       switch_pulse,
  output logic [7:0] switch_cnt
);
  localparam int DW = $clog2(MIN_DWELL + 1);
  state_t state, nxt;
  logic [15:0] hold_cnt;
  logic [DW-1:0] dwell;
  logic fa_s, fb_s, fa, fb, dwell_exp, hold_done, revert, done_sw;
  logic n_sel, n_a_en, n_b_en;
  sync2 u_sync_a (.clk(clk), .rst(rst), .d(force_a), .q(fa_s));
  sync2 u_sync_b (.clk(clk), .rst(rst), .d(force_b), .q(fb_s));
  assign fa = fa_s & ~fb_s;
  assign fb = fb_s & ~fa_s;
  assign dwell_exp = dwell == DW'(MIN_DWELL);
  assign hold_done = hold_cnt == 16'(HOLDOFF - 1);
`ifdef CORE_SWITCH_REVERT_EN
  localparam int RW = $clog2(REVERT_TIME + 1);
  logic [RW-1:0] rev_cnt;
  assign revert = a_ok && !fa && !fb && rev_cnt == RW'(REVERT_TIME - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) rev_cnt <= '0;
    else rev_cnt <= (state == ST_RUN_B && nxt == ST_RUN_B && a_ok) ? rev_cnt + RW'(1) : '0;
`else
  assign revert = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      ST_INIT:  nxt = a_ok ? ST_RUN_A : b_ok ? ST_RUN_B : ST_FAIL;
      ST_RUN_A: nxt = (fb || (!a_ok && b_ok && dwell_exp)) ? ST_SW_B :
                      (!a_ok && !b_ok) ? ST_FAIL : ST_RUN_A;
      ST_RUN_B: nxt = (fa || (!b_ok && a_ok && dwell_exp)) ? ST_SW_A :
                      (!a_ok && !b_ok) ? ST_FAIL : revert ? ST_SW_A : ST_RUN_B;
      ST_SW_A:  nxt = hold_done ? ST_RUN_A : ST_SW_A;
      ST_SW_B:  nxt = hold_done ? ST_RUN_B : ST_SW_B;
      ST_FAIL:  nxt = (sel_a ? a_ok : b_ok) ? (sel_a ? ST_RUN_A : ST_RUN_B) :
                      (sel_a ? b_ok : a_ok) ? (sel_a ? ST_SW_B : ST_SW_A) : ST_FAIL;
      default:  nxt = ST_INIT;
    endcase
  end
  // FAIL freezes whatever mux/enable setting was in force when it was entered
  assign n_sel   = (nxt == ST_FAIL) ? sel_a : (nxt inside {ST_INIT, ST_RUN_A, ST_SW_A});
  assign n_a_en  = (nxt == ST_FAIL) ? a_en : (nxt == ST_RUN_A);
  assign n_b_en  = (nxt == ST_FAIL) ? b_en : (nxt == ST_RUN_B);
  assign done_sw = (state == ST_SW_A && nxt == ST_RUN_A) || (state == ST_SW_B && nxt == ST_RUN_B);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= ST_INIT;
      sel_a        <= 1'b1;
      a_en         <= 1'b0;
      b_en         <= 1'b0;
      fault        <= 1'b0;
      switch_pulse <= 1'b0;
      switch_cnt   <= 8'd0;
      hold_cnt     <= 16'd0;
      dwell        <= '0;
    end else begin
      state        <= nxt;
      sel_a        <= n_sel;
      a_en         <= n_a_en;
      b_en         <= n_b_en;
      fault        <= nxt == ST_FAIL;
      switch_pulse <= done_sw;
      switch_cnt   <= (done_sw && switch_cnt != 8'hff) ? switch_cnt + 8'd1 : switch_cnt;
      hold_cnt     <= (nxt == state && (state == ST_SW_A || state == ST_SW_B)) ? hold_cnt + 16'd1 : 16'd0;
      dwell        <= (nxt != state) ? '0 : dwell_exp ? dwell : dwell + DW'(1);
    end
endmodule
